// File: rtl/axi_stream_extract_header_pkg.sv
// Shared types for the header extractor: FSM states and keep/byte-count helper.
// No clocked logic, no latency, no backpressure.
package axi_stream_extract_header_pkg;

  localparam int KEEP_MAX = 64;

  typedef enum logic [1:0] {
    HEAD  = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Counts valid byte lanes; keep is contiguous from the MSB so a popcount suffices.
  function automatic logic [7:0] keep_to_cnt(input logic [KEEP_MAX-1:0] keep);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      cnt = cnt + 8'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axi_stream_extract_header_if.sv
// AXI-Stream style bundle shared by the input, payload and header ports.
// Pure wiring: no latency; backpressure carried on ready.
interface axi_stream_extract_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WD-1:0]      data;
  logic [DATA_BYTE_WD-1:0] keep;
  logic                    last;

  modport master (output valid, data, keep, last, input ready);
  modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/skidbuffer.sv
// Two-entry registered skid buffer: one-cycle latency, full throughput.
// s_ready is a flop (skid slot empty), so it never depends on m_ready combinationally.
module skidbuffer #(
  parameter int DW = 37
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
);

  logic          skid_valid;
  logic [DW-1:0] skid_data;
  logic          s_fire;

  assign s_ready = !skid_valid;
  assign s_fire  = s_valid && !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!m_valid || m_ready) begin
      if (skid_valid) begin
        m_valid    <= 1'b1;
        m_data     <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else begin
        m_valid <= s_fire;
        m_data  <= s_fire ? s_data : '0;
      end
    end else if (s_fire) begin
      // Output is stalled: park the incoming beat so s_ready can drop a cycle later.
      skid_valid <= 1'b1;
      skid_data  <= s_data;
    end
  end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips the first N bytes of each packet onto a one-entry header port and realigns the rest.
// Payload latency one cycle via skid buffer; a full header slot only blocks the next first beat.
module axi_stream_extract_header
  import axi_stream_extract_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi_stream_extract_header_if.slave  axis_in,
  input  logic [BYTE_CNT_WD-1:0] byte_extract_cnt,
  axi_stream_extract_header_if.master axis_out,
  axi_stream_extract_header_if.master axis_header
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam int SW = DATA_WD + DATA_BYTE_WD + 1;
  localparam logic [DATA_BYTE_WD-1:0] KEEP_ONES = '1;
  localparam logic [CW-1:0]           BYTES     = CW'(DATA_BYTE_WD);

  state_t                  state;
  logic                    init_done;
  logic [CW-1:0]           n_reg;
  logic [CW-1:0]           res_cnt;
  logic [DATA_WD-1:0]      res;
  logic                    hdr_valid;
  logic [DATA_WD-1:0]      hdr_data;
  logic [DATA_BYTE_WD-1:0] hdr_keep;

  logic [DATA_WD-1:0]      din_m;
  logic [CW-1:0]           k_in, n_cur, hdr_cnt;
  logic                    tail_short, hdr_free, in_rdy, fire;
  logic                    push, push_rdy, push_last;
  logic [DATA_WD-1:0]      push_data;
  logic [DATA_BYTE_WD-1:0] push_keep;
  logic [SW-1:0]           out_bus;

  function automatic logic [DATA_BYTE_WD-1:0] keep_msb(input logic [CW-1:0] cnt);
    return ~(KEEP_ONES >> cnt);
  endfunction

  always_comb begin
    din_m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      if (axis_in.keep[i]) din_m[8*i +: 8] = axis_in.data[8*i +: 8];
    end
  end

  assign k_in       = CW'(keep_to_cnt(KEEP_MAX'(axis_in.keep)));
  assign n_cur      = (state == HEAD) ? CW'(byte_extract_cnt) + CW'(1) : n_reg;
  assign tail_short = axis_in.last && (k_in <= n_cur);
  assign hdr_cnt    = tail_short ? k_in : n_cur;
  assign hdr_free   = !hdr_valid || axis_header.ready;

  always_comb begin
    in_rdy = 1'b0;
    case (state)
      HEAD:    in_rdy = hdr_free;
      BODY:    in_rdy = push_rdy;
      default: in_rdy = 1'b0;
    endcase
  end

  assign axis_in.ready = init_done && in_rdy;
  assign fire          = axis_in.valid && axis_in.ready;

  // Residual sits left-aligned in res; the next beat's head bytes fill the tail lanes.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_keep = '0;
    push_last = 1'b0;
    if (state == BODY && fire) begin
      push      = 1'b1;
      push_data = res | (din_m >> (8 * int'(BYTES - n_cur)));
      push_keep = tail_short ? keep_msb(res_cnt + k_in) : KEEP_ONES;
      push_last = tail_short;
    end else if (state == FLUSH) begin
      push      = 1'b1;
      push_data = res;
      push_keep = keep_msb(res_cnt);
      push_last = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HEAD;
      init_done <= 1'b0;
      n_reg     <= '0;
      res       <= '0;
      res_cnt   <= '0;
      hdr_valid <= 1'b0;
      hdr_data  <= '0;
      hdr_keep  <= '0;
    end else begin
      init_done <= 1'b1;

      if (state == HEAD && fire) begin
        hdr_valid <= 1'b1;
        hdr_data  <= din_m >> (8 * int'(BYTES - hdr_cnt));
        hdr_keep  <= ~(KEEP_ONES << hdr_cnt);
      end else if (axis_header.ready) begin
        hdr_valid <= 1'b0;
        hdr_data  <= '0;
        hdr_keep  <= '0;
      end

      case (state)
        HEAD: if (fire) begin
          n_reg   <= n_cur;
          res     <= din_m << (8 * int'(n_cur));
          res_cnt <= BYTES - n_cur;
          if (!axis_in.last) begin
            state <= BODY;
          end else if (!tail_short) begin
            res_cnt <= k_in - n_cur;
            state   <= FLUSH;
          end else begin
            res     <= '0;
            res_cnt <= '0;
          end
        end
        BODY: if (fire) begin
          res <= din_m << (8 * int'(n_cur));
          if (axis_in.last) begin
            if (tail_short) begin
              res     <= '0;
              res_cnt <= '0;
              state   <= HEAD;
            end else begin
              res_cnt <= k_in - n_cur;
              state   <= FLUSH;
            end
          end
        end
        FLUSH: if (push_rdy) begin
          res     <= '0;
          res_cnt <= '0;
          state   <= HEAD;
        end
        default: state <= HEAD;
      endcase
    end
  end

  skidbuffer #(.DW(SW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (push),
    .s_ready (push_rdy),
    .s_data  ({push_data, push_keep, push_last}),
    .m_valid (axis_out.valid),
    .m_ready (axis_out.ready),
    .m_data  (out_bus)
  );

  assign {axis_out.data, axis_out.keep, axis_out.last} = out_bus;

  assign axis_header.valid = hdr_valid;
  assign axis_header.data  = hdr_data;
  assign axis_header.keep  = hdr_keep;
  assign axis_header.last  = 1'b0;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Scoreboard bench for axi_stream_extract_header: directed packets, random packets, stalls, reset.
module tb_axi_stream_extract_header;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] byte_extract_cnt;
  bit         rand_rdy    = 1'b0;
  bit         out_rdy_set = 1'b1;
  bit         hdr_rdy_set = 1'b1;
  bit         rnd_o       = 1'b0;
  bit         rnd_h       = 1'b0;
  int         checks      = 0;
  int         errors      = 0;
  beat_t      exp_pay[$];
  beat_t      exp_hdr[$];

  axi_stream_extract_header_if #(.DATA_WD(32)) in_if ();
  axi_stream_extract_header_if #(.DATA_WD(32)) out_if ();
  axi_stream_extract_header_if #(.DATA_WD(32)) hdr_if ();

  axi_stream_extract_header #(.DATA_WD(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .axis_in          (in_if),
    .byte_extract_cnt (byte_extract_cnt),
    .axis_out         (out_if),
    .axis_header      (hdr_if)
  );

  always #5 clk = ~clk;

  assign out_if.ready = rand_rdy ? rnd_o : out_rdy_set;
  assign hdr_if.ready = rand_rdy ? rnd_h : hdr_rdy_set;

  always @(posedge clk) begin
    #1;
    rnd_o = 1'($urandom_range(0, 1));
    rnd_h = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_if.valid && out_if.ready) begin
        if (exp_pay.size() == 0) begin
          checks++; errors++;
          $display("FAIL payload_unexpected: got 0x%0h, expected no beat",
                   {out_if.data, out_if.keep, out_if.last});
        end else begin
          check("payload_beat", 64'({out_if.data, out_if.keep, out_if.last}), 64'(exp_pay.pop_front()));
        end
      end
      if (hdr_if.valid && hdr_if.ready) begin
        if (exp_hdr.size() == 0) begin
          checks++; errors++;
          $display("FAIL header_unexpected: got 0x%0h, expected no header", {hdr_if.data, hdr_if.keep});
        end else begin
          check("header_beat", 64'({hdr_if.data, hdr_if.keep, hdr_if.last}), 64'(exp_hdr.pop_front()));
        end
      end
    end
  end

  task automatic push_pay(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    exp_pay.push_back(b);
  endtask

  task automatic push_hdr(input logic [31:0] d, input logic [3:0] k);
    beat_t b;
    b.data = d; b.keep = k; b.last = 1'b0;
    exp_hdr.push_back(b);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok = 1'b0;
    in_if.valid = 1'b1; in_if.data = d; in_if.keep = k; in_if.last = l;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      if (in_if.ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_if.valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat 0x%0h not accepted in 500 cycles, expected acceptance", d);
    end
  endtask

  task automatic drain(input string name);
    int c = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && c < 3000) begin
      @(posedge clk); c++;
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_pay.size() != 0 || exp_hdr.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d payload and %0d header outstanding, expected 0",
               name, exp_pay.size(), exp_hdr.size());
    end
  endtask

  task automatic random_packet();
    logic [7:0]  b[$];
    logic [31:0] d;
    logic [3:0]  k;
    int n, len, h;
    n   = $urandom_range(1, 4);
    len = $urandom_range(1, 12);
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    h = (len < n) ? len : n;
    d = '0;
    for (int i = 0; i < h; i++) d = {d[23:0], b[i]};
    push_hdr(d, 4'((1 << h) - 1));
    for (int p = h; p < len; p += 4) begin
      d = '0; k = '0;
      for (int j = 0; j < 4; j++) if (p + j < len) begin
        d[31-8*j -: 8] = b[p+j];
        k[3-j] = 1'b1;
      end
      push_pay(d, k, p + 4 >= len);
    end
    byte_extract_cnt = 2'(n - 1);
    for (int p = 0; p < len; p += 4) begin
      d = $urandom; k = '0;
      for (int j = 0; j < 4; j++) if (p + j < len) begin
        d[31-8*j -: 8] = b[p+j];
        k[3-j] = 1'b1;
      end
      send_beat(d, k, p + 4 >= len);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_if.valid = 1'b0; in_if.data = '0; in_if.keep = '0; in_if.last = 1'b0;
    byte_extract_cnt = '0;
    #22;
    check("rst_valid_out", 64'(out_if.valid), 64'(0));
    check("rst_valid_header", 64'(hdr_if.valid), 64'(0));
    check("rst_ready_in", 64'(in_if.ready), 64'(0));
    check("rst_out_bus", 64'({out_if.data, out_if.keep, out_if.last}), 64'(0));
    check("rst_hdr_bus", 64'({hdr_if.data, hdr_if.keep}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("ready_in_after_release", 64'(in_if.ready), 64'(0));
    @(posedge clk); #1;
    check("ready_in_first_edge", 64'(in_if.ready), 64'(1));

    // N=2, last beat two bytes
    byte_extract_cnt = 2'd1;
    push_hdr(32'h0000A0A1, 4'b0011);
    push_pay(32'hA2A3B0B1, 4'b1111, 1'b0);
    push_pay(32'hB2B3C0C1, 4'b1111, 1'b1);
    send_beat(32'hA0A1A2A3, 4'b1111, 1'b0);
    send_beat(32'hB0B1B2B3, 4'b1111, 1'b0);
    send_beat(32'hC0C1C2C3, 4'b1100, 1'b1);
    drain("n2_short_tail");

    // N=2, last beat three bytes -> flush beat
    push_hdr(32'h0000A0A1, 4'b0011);
    push_pay(32'hA2A3B0B1, 4'b1111, 1'b0);
    push_pay(32'hB2B3C0C1, 4'b1111, 1'b0);
    push_pay(32'hC2000000, 4'b1000, 1'b1);
    send_beat(32'hA0A1A2A3, 4'b1111, 1'b0);
    send_beat(32'hB0B1B2B3, 4'b1111, 1'b0);
    send_beat(32'hC0C1C2C3, 4'b1110, 1'b1);
    check("flush_ready_in", 64'(in_if.ready), 64'(0));
    drain("n2_flush");

    // N=4, single short beat: header only
    byte_extract_cnt = 2'd3;
    push_hdr(32'h00D0D1D2, 4'b0111);
    send_beat(32'hD0D1D2D3, 4'b1110, 1'b1);
    drain("n4_header_only");

    // Header stall: payload of current packet completes, next first beat waits
    byte_extract_cnt = 2'd1;
    hdr_rdy_set = 1'b0;
    push_hdr(32'h00001011, 4'b0011);
    push_pay(32'h12131400, 4'b1110, 1'b1);
    send_beat(32'h10111213, 4'b1111, 1'b0);
    send_beat(32'h14151617, 4'b1000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("stall_payload_done", 64'(exp_pay.size()), 64'(0));
    check("stall_header_held", 64'(hdr_if.valid), 64'(1));
    in_if.valid = 1'b1; in_if.data = 32'h20212223; in_if.keep = 4'b1111; in_if.last = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("hdr_stall_blocks", 64'(in_if.ready), 64'(0));
    end
    @(posedge clk); #1;
    hdr_rdy_set = 1'b1;
    push_hdr(32'h00002021, 4'b0011);
    push_pay(32'h22230000, 4'b1100, 1'b1);
    send_beat(32'h20212223, 4'b1111, 1'b1);
    drain("hdr_stall");

    // Random packets under random backpressure on both outputs
    rand_rdy = 1'b1;
    for (int p = 0; p < 100; p++) random_packet();
    drain("random");
    rand_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of BODY
    out_rdy_set = 1'b0;
    hdr_rdy_set = 1'b0;
    byte_extract_cnt = 2'd1;
    send_beat(32'hE0E1E2E3, 4'b1111, 1'b0);
    send_beat(32'hF0F1F2F3, 4'b1111, 1'b0);
    check("pre_reset_valid_out", 64'(out_if.valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", 64'(out_if.valid), 64'(0));
    check("midrst_valid_header", 64'(hdr_if.valid), 64'(0));
    check("midrst_ready_in", 64'(in_if.ready), 64'(0));
    check("midrst_out_bus", 64'({out_if.data, out_if.keep, out_if.last}), 64'(0));
    check("midrst_hdr_bus", 64'({hdr_if.data, hdr_if.keep}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_rdy_set = 1'b1;
    hdr_rdy_set = 1'b1;
    byte_extract_cnt = 2'd2;
    push_hdr(32'h00112233, 4'b0111);
    push_pay(32'h44556600, 4'b1110, 1'b1);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h556677AA, 4'b1100, 1'b1);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
